// File: rtl/regfile_read_port.sv
// regfile_read_port: 32 x n register file for the ID stage.
// It has two registered read ports with write-first bypass and stall hold/refresh.
// Flush zeroes both read outputs to inject a bubble into EX.
// A pending-load scoreboard drives a combinational load-use hazard flag.
module regfile_read_port #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic [4:0]   rs_addr,
    input  logic [4:0]   rt_addr,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [n-1:0] wr_data,
    input  logic         busy_set,
    input  logic [4:0]   busy_addr,
    output logic [n-1:0] rs_data,
    output logic [n-1:0] rt_data,
    output logic         hazard
);

    // Storage. Entry 0 is never written, so it stays at its reset value of zero.
    logic [n-1:0] entry_reg [32];
    logic [31:0]  busy_reg;
    logic [31:0]  busy_next;
    logic [31:0]  set_vec;
    logic [31:0]  clr_vec;

    // Captured read addresses and registered operands.
    logic [4:0]   rs_q_reg;
    logic [4:0]   rt_q_reg;
    logic [n-1:0] rs_data_reg;
    logic [n-1:0] rt_data_reg;

    // Read selection: a stalled stage re-reads its held address.
    logic [4:0]   rs_sel;
    logic [4:0]   rt_sel;
    logic [n-1:0] rs_next;
    logic [n-1:0] rt_next;

    // One-hot set/clear masks per register. Bit 0 is masked off so r0 is never busy.
    always_comb begin
        set_vec   = busy_set ? (32'd1 << busy_addr) : 32'd0;
        clr_vec   = wr_en ? (32'd1 << wr_addr) : 32'd0;
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
        // Set wins over clear: a newly issued load is still in flight.
        busy_next = (busy_reg & ~clr_vec) | set_vec;
    end

    // Write-first bypassed read of the live or held address.
    always_comb begin
        rs_sel  = stall ? rs_q_reg : rs_addr;
        rt_sel  = stall ? rt_q_reg : rt_addr;
        rs_next = '0;
        rt_next = '0;
        if (rs_sel != 5'd0) begin
            rs_next = (wr_en && wr_addr == rs_sel) ? wr_data : entry_reg[rs_sel];
        end
        if (rt_sel != 5'd0) begin
            rt_next = (wr_en && wr_addr == rt_sel) ? wr_data : entry_reg[rt_sel];
        end
    end

    // Load-use hazard. A same-cycle writeback of the register resolves it through the bypass.
    always_comb begin
        hazard = 1'b0;
        if (rs_addr != 5'd0 && busy_reg[rs_addr] && !clr_vec[rs_addr]) begin
            hazard = 1'b1;
        end
        if (rt_addr != 5'd0 && busy_reg[rt_addr] && !clr_vec[rt_addr]) begin
            hazard = 1'b1;
        end
    end

    // Register storage and scoreboard. Writes happen regardless of stall or flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                entry_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                entry_reg[wr_addr] <= wr_data;
            end
            busy_reg <= busy_next;
        end
    end

    // Read port pipeline register: flush beats stall, and stall refreshes the held operands.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rs_q_reg    <= '0;
            rt_q_reg    <= '0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
        end else begin
            if (!stall) begin
                rs_q_reg <= rs_addr;
                rt_q_reg <= rt_addr;
            end
            rs_data_reg <= rs_next;
            rt_data_reg <= rt_next;
        end
    end

    assign rs_data = rs_data_reg;
    assign rt_data = rt_data_reg;

endmodule

// File: tb/tb_regfile_read_port.sv
// Testbench for regfile_read_port.
// It applies a directed vector table, then random traffic checked against a behavioural model.
module tb_regfile_read_port;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset, stall, flush, wr_en, busy_set;
    logic [4:0]   rs_addr, rt_addr, wr_addr, busy_addr;
    logic [N-1:0] wr_data;
    logic [N-1:0] rs_data, rt_data;
    logic         hazard;

    regfile_read_port #(.n(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .hazard    (hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          stl;
        bit          fls;
        logic [4:0]  rs;
        logic [4:0]  rt;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          bs;
        logic [4:0]  ba;
        logic [31:0] ers;
        logic [31:0] ert;
        bit          ehz;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    // Behavioural model: architectural registers, pending-load set and the ID/EX operand latch.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [4:0]  m_rsq, m_rtq;
    logic [31:0] m_rs, m_rt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic bit model_hazard(input vec_t v);
        bit h = 0;
        if (v.rs != 0 && m_busy[v.rs] && !(v.we && v.wa == v.rs)) h = 1;
        if (v.rt != 0 && m_busy[v.rt] && !(v.we && v.wa == v.rt)) h = 1;
        return h;
    endfunction

    // The write lands first and r0 is pinned to zero, so a read after it sees the bypassed value.
    task automatic model_edge(input vec_t v);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 0;
                m_busy[i] = 0;
            end
            m_rsq = 0; m_rtq = 0; m_rs = 0; m_rt = 0;
            return;
        end
        if (v.we && v.wa != 0) m_regs[v.wa] = v.wd;
        if (v.fls) begin
            m_rsq = 0; m_rtq = 0; m_rs = 0; m_rt = 0;
        end else begin
            if (!v.stl) begin
                m_rsq = v.rs;
                m_rtq = v.rt;
            end
            m_rs = m_regs[m_rsq];
            m_rt = m_regs[m_rtq];
        end
        for (int r = 1; r < 32; r++) begin
            if (v.bs && v.ba == r) m_busy[r] = 1;
            else if (v.we && v.wa == r) m_busy[r] = 0;
        end
    endtask

    // One clock of stimulus. The hazard flag is checked before the edge and the operands just after it.
    task automatic step(input vec_t v, input bit use_table, input int idx);
        logic [31:0] eh;
        @(negedge clk);
        reset = v.rst; stall = v.stl; flush = v.fls;
        rs_addr = v.rs; rt_addr = v.rt;
        wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
        busy_set = v.bs; busy_addr = v.ba;
        #1;
        eh = use_table ? 32'(v.ehz) : 32'(model_hazard(v));
        check($sformatf("hazard[%0d]", idx), 32'(hazard), eh);
        @(posedge clk);
        model_edge(v);
        #1;
        check($sformatf("rs_data[%0d]", idx), rs_data, use_table ? v.ers : m_rs);
        check($sformatf("rt_data[%0d]", idx), rt_data, use_table ? v.ert : m_rt);
        $display("cyc %0d rst=%0b stl=%0b fls=%0b rs=%0d rt=%0d we=%0b wa=%0d wd=%h bs=%0b ba=%0d -> rs_data=%h rt_data=%h hazard=%0b",
                 idx, v.rst, v.stl, v.fls, v.rs, v.rt, v.we, v.wa, v.wd, v.bs, v.ba, rs_data, rt_data, eh[0]);
    endtask

    function automatic void add(bit rst, bit stl, bit fls, int rs, int rt, bit we, int wa,
                                logic [31:0] wd, bit bs, int ba,
                                logic [31:0] ers, logic [31:0] ert, bit ehz);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fls = fls;
        v.rs = 5'(rs); v.rt = 5'(rt); v.we = we; v.wa = 5'(wa); v.wd = wd;
        v.bs = bs; v.ba = 5'(ba); v.ers = ers; v.ert = ert; v.ehz = ehz;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t v;
        reset = 1; stall = 0; flush = 0; rs_addr = 0; rt_addr = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0; busy_set = 0; busy_addr = 0;

        //  rst stl fls rs rt we wa wd            bs ba  exp_rs        exp_rt        hz
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        0); // reset
        add(0, 0, 0, 5, 0, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF,  0, 0, 32'h0,        32'h0,        0);
        add(0, 0, 0, 7, 0, 0, 0, 32'h0,         0, 0, 32'hDEADBEEF, 32'h0,        0);
        add(0, 0, 0, 7, 0, 1, 0, 32'h1234,      0, 0, 32'hDEADBEEF, 32'h0,        0); // r0 write dropped
        add(0, 0, 0, 0, 0, 1, 9, 32'h11,        0, 0, 32'h0,        32'h0,        0);
        add(0, 0, 0, 9, 9, 1, 9, 32'hA5A5A5A5,  0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0); // bypass
        add(0, 0, 0, 0, 0, 1, 3, 32'h10,       0, 0, 32'h0,        32'h0,        0);
        add(0, 0, 0, 3, 0, 0, 0, 32'h0,         0, 0, 32'h10,       32'h0,        0);
        add(0, 1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h10,       32'h0,        0); // stall 1
        add(0, 1, 0, 0, 0, 1, 3, 32'h20,        0, 0, 32'h20,       32'h0,        0); // stall 2 + write
        add(0, 1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h20,       32'h0,        0); // stall 3
        add(0, 1, 1, 3, 0, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        0); // flush+stall
        add(0, 1, 0, 3, 0, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        0); // held addr now 0
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,         1, 4, 32'h0,        32'h0,        0); // load r4
        add(0, 0, 0, 4, 0, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        1);
        add(0, 0, 0, 4, 0, 1, 4, 32'h55,        0, 0, 32'h55,       32'h0,        0); // WB resolves
        add(0, 0, 0, 4, 0, 0, 0, 32'h0,         0, 0, 32'h55,       32'h0,        0); // busy cleared
        add(0, 0, 0, 0, 4, 1, 4, 32'h66,        1, 4, 32'h0,        32'h66,       0); // set beats clr
        add(0, 0, 0, 0, 4, 0, 0, 32'h0,         0, 0, 32'h0,        32'h66,       1);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,         1, 0, 32'h0,        32'h0,        0); // r0 never busy
        add(0, 0, 0, 0, 0, 1, 6, 32'h77,        0, 0, 32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,         1, 6, 32'h0,        32'h0,        0);
        add(0, 0, 0, 6, 6, 0, 0, 32'h0,         0, 0, 32'h77,       32'h77,       1);
        add(0, 1, 0, 6, 6, 0, 0, 32'h0,         0, 0, 32'h77,       32'h77,       1);
        add(1, 1, 0, 6, 6, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        1); // reset wins
        add(0, 0, 0, 6, 6, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        0);
        add(0, 0, 0, 6, 0, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        0);

        foreach (vecs[i]) step(vecs[i], 1'b1, i);

        // Random traffic on a narrow address range to force collisions.
        for (int c = 0; c < 400; c++) begin
            v.rst = ($urandom_range(0, 99) < 2);
            v.stl = ($urandom_range(0, 99) < 25);
            v.fls = ($urandom_range(0, 99) < 10);
            v.rs  = 5'($urandom_range(0, 7));
            v.rt  = 5'($urandom_range(0, 7));
            v.we  = ($urandom_range(0, 99) < 50);
            v.wa  = 5'($urandom_range(0, 7));
            v.wd  = $urandom;
            v.bs  = ($urandom_range(0, 99) < 30);
            v.ba  = 5'($urandom_range(0, 7));
            v.ers = 0; v.ert = 0; v.ehz = 0;
            step(v, 1'b0, 1000 + c);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
